// File: rtl/cpu_defs.sv
// Shared CPU front-end definitions: address/instruction widths, PC reset and step,
// and the fetch FSM state encoding.
package cpu_defs;

  localparam int ADDR_W   = 5;
  localparam int INST_W   = 32;
  localparam int PC_STEP  = 4;
  localparam int RESET_PC = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter register: synchronous reset, sequential increment and
// word-aligned redirect load. Redirect load wins over increment.
module fetch_pc_reg #(
  parameter int ADDR_W   = cpu_defs::ADDR_W,
  parameter int PC_STEP  = cpu_defs::PC_STEP,
  parameter int RESET_PC = cpu_defs::RESET_PC
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  output logic [ADDR_W-1:0] pc
);

  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_q;

  always_comb begin
    // NOTE: default assignment first so every path drives pc_d and no latch is inferred.
    pc_d = pc_q;
    if (load) begin
      pc_d = load_pc & ~ADDR_W'(3);
    end else if (inc) begin
      // Wraps modulo 2^ADDR_W with no flag.
      pc_d = pc_q + ADDR_W'(PC_STEP);
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
    if (rst) begin
      pc_q <= ADDR_W'(RESET_PC);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: drives the ROM address from the PC, registers each
// returned word with its PC and hands it to decode over a valid/ready handshake.
module inst_fetch_unit #(
  parameter int ADDR_W   = cpu_defs::ADDR_W,
  parameter int INST_W   = cpu_defs::INST_W,
  parameter int RESET_PC = cpu_defs::RESET_PC,
  parameter int PC_STEP  = cpu_defs::PC_STEP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] rom_pc,
  input  logic [INST_W-1:0] rom_inst,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [INST_W-1:0] out_inst
);

  import cpu_defs::*;

  fetch_state_e      state_d, state_q;
  logic              out_valid_d, out_valid_q;
  logic [ADDR_W-1:0] out_pc_d, out_pc_q;
  logic [INST_W-1:0] out_inst_d, out_inst_q;

  logic              pc_inc;
  logic              pc_load;
  logic [ADDR_W-1:0] pc;
  logic              slot_free;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  // The output slot may be refilled only when empty or being drained this cycle.
  assign slot_free = !out_valid_q || out_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;

    if (redirect_valid) begin
      // A word accepted this cycle still completes; anything left is squashed.
      pc_load     = 1'b1;
      out_valid_d = 1'b0;
      state_d     = en ? ST_FETCH : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) state_d = ST_FETCH;
        end
        ST_FETCH: begin
          if (!slot_free) begin
            state_d = ST_HOLD;
          end else if (en) begin
            out_inst_d  = rom_inst;
            out_pc_d    = pc;
            out_valid_d = 1'b1;
            pc_inc      = 1'b1;
          end else begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = en ? ST_FETCH : ST_IDLE;
          end
        end
        default: begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      out_inst_q  <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
    end
  end

  assign rom_pc    = pc;
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Scoreboard bench for inst_fetch_unit: stimulus queues expected accepted words,
// a negedge monitor pops and compares on every valid/ready handshake.
module tb_inst_fetch_unit;

  typedef struct packed {
    logic [4:0]  pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  rom_pc;
  logic [31:0] rom_inst;
  logic        redirect_valid;
  logic [4:0]  redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_pc;
  logic [31:0] out_inst;

  exp_t sb[$];
  exp_t mon_exp;
  int   total = 0;
  int   bad   = 0;
  int   n_acc = 0;

  inst_fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .rom_pc         (rom_pc),
    .rom_inst       (rom_inst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  always #5 clk = ~clk;

  assign rom_inst = 32'hA000_0000 | {27'b0, rom_pc};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [4:0] pc);
    exp_t e;
    e.pc   = pc;
    e.inst = 32'hA000_0000 | {27'b0, pc};
    sb.push_back(e);
  endtask

  task automatic wait_out_pc(input logic [4:0] target, input int budget);
    int n;
    n = 0;
    while (!(out_valid && out_pc == target) && n < budget) begin
      tick();
      n++;
    end
    check("reach_out_pc", {31'b0, (out_valid && out_pc == target)}, 32'd1);
  endtask

  // Monitor: every handshake must match the oldest expected word.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", {27'b0, out_pc}, 32'hFFFF_FFFF);
      end else begin
        mon_exp = sb.pop_front();
        check("sb_out_pc", {27'b0, out_pc}, {27'b0, mon_exp.pc});
        check("sb_out_inst", out_inst, mon_exp.inst);
        n_acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst            = 1'b1;
    en             = 1'b0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 5'd0;

    // 1: reset state
    tick();
    tick();
    rst = 1'b0;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_pc", {27'b0, out_pc}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_rom_pc", {27'b0, rom_pc}, 32'd0);

    // 2: full-rate stream with wrap 28 -> 0
    en        = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) push_exp(5'((i * 4) % 32));
    repeat (10) tick();
    en = 1'b0;
    tick();
    check("stream_accepted", n_acc, 32'd9);
    check("stream_idle_valid", {31'b0, out_valid}, 32'd0);

    // Redirect while idle, misaligned target 3 -> 0, no fetch without en
    redirect_valid = 1'b1;
    redirect_pc    = 5'd3;
    tick();
    redirect_valid = 1'b0;
    check("idle_redir_rom_pc", {27'b0, rom_pc}, 32'd0);
    check("idle_redir_valid", {31'b0, out_valid}, 32'd0);

    // 3: stall at out_pc=8 for 3 cycles
    en = 1'b1;
    push_exp(5'd0);
    push_exp(5'd4);
    push_exp(5'd8);
    wait_out_pc(5'd8, 10);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", {31'b0, out_valid}, 32'd1);
      check("stall_out_pc", {27'b0, out_pc}, 32'd8);
      check("stall_out_inst", out_inst, 32'hA000_0008);
      check("stall_rom_pc", {27'b0, rom_pc}, 32'd12);
    end
    out_ready = 1'b1;
    push_exp(5'd12);
    push_exp(5'd16);
    wait_out_pc(5'd16, 10);

    // 4: redirect to 22 during stream; word 16 is consumed in the same cycle
    redirect_valid = 1'b1;
    redirect_pc    = 5'd22;
    tick();
    redirect_valid = 1'b0;
    check("redir_bubble_valid", {31'b0, out_valid}, 32'd0);
    check("redir_rom_pc", {27'b0, rom_pc}, 32'd20);
    push_exp(5'd20);
    push_exp(5'd24);
    tick();
    check("redir_first_pc", {27'b0, out_pc}, 32'd20);
    check("redir_first_valid", {31'b0, out_valid}, 32'd1);
    tick();
    check("redir_second_pc", {27'b0, out_pc}, 32'd24);

    // 5: get word 4 into HOLD, then redirect to 16 discards it
    redirect_valid = 1'b1;
    redirect_pc    = 5'd4;
    tick();
    redirect_valid = 1'b0;
    out_ready      = 1'b0;
    tick();
    check("hold_setup_valid", {31'b0, out_valid}, 32'd1);
    check("hold_setup_pc", {27'b0, out_pc}, 32'd4);
    tick();
    check("hold_out_pc", {27'b0, out_pc}, 32'd4);
    check("hold_rom_pc", {27'b0, rom_pc}, 32'd8);
    redirect_valid = 1'b1;
    redirect_pc    = 5'd16;
    tick();
    redirect_valid = 1'b0;
    check("hold_redir_valid", {31'b0, out_valid}, 32'd0);
    check("hold_redir_rom_pc", {27'b0, rom_pc}, 32'd16);
    out_ready = 1'b1;
    push_exp(5'd16);
    push_exp(5'd20);
    push_exp(5'd24);
    push_exp(5'd28);
    push_exp(5'd0);
    push_exp(5'd4);
    push_exp(5'd8);
    wait_out_pc(5'd12, 20);

    // 6: reset mid-stream with word 12 presented but not accepted
    out_ready = 1'b0;
    rst       = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_rom_pc", {27'b0, rom_pc}, 32'd0);
    check("midrst_out_pc", {27'b0, out_pc}, 32'd0);
    out_ready = 1'b1;
    push_exp(5'd0);
    push_exp(5'd4);
    wait_out_pc(5'd4, 10);
    en = 1'b0;
    repeat (3) tick();

    check("sb_drained", sb.size(), 32'd0);
    check("total_accepted", n_acc, 32'd25);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
